conv_stream_engine: RTL and testbench

- Parametrised successor to the single-layer convolution accelerator.
- Computes M output feature maps from N input channels with a KxK kernel, any stride, and signed DW-bit data.
- Adds per-run requantisation: arithmetic right shift with rounding, optional ReLU, and signed saturation.
- Sits between four on-chip block RAMs (input, weight, bias, output) and the host control logic. Driven by a start/busy/done handshake.

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_mac.sv | 67 ++++++
 rtl/conv_stream_engine.sv | 152 +++++++++++++++
 tb/tb_conv_stream_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the streaming convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {StIdle, StIssue, StFlush, StWrite, StDone} state_e;

  localparam int unsigned SatW = 128;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned ro_of(input int unsigned r, input int unsigned k,
                                        input int unsigned s);
    return (r - k) / s + 1;
  endfunction

  function automatic int unsigned co_of(input int unsigned c, input int unsigned k,
                                        input int unsigned s);
    return (c - k) / s + 1;
  endfunction

  function automatic int unsigned taps_of(input int unsigned n, input int unsigned k);
    return n * k * k;
  endfunction

  // Clamp a wide signed value into the dw-bit two's-complement range.
  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] value,
                                                      input int unsigned dw);
    logic signed [SatW-1:0] hi, lo;
    hi = signed'((SatW'(1) << (dw - 1)) - SatW'(1));
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Two-stage multiply/accumulate datapath with rounding shift, ReLU and saturation.
module conv_mac import conv_pkg::*; #(
  parameter int unsigned DW   = 16,
  parameter int unsigned ACCW = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tap_valid_i,
  input  logic                   tap_first_i,
  input  logic signed [DW-1:0]   i_rdata_i,
  input  logic signed [DW-1:0]   w_rdata_i,
  input  logic signed [2*DW-1:0] b_rdata_i,
  input  logic [5:0]             shift_i,
  input  logic                   relu_en_i,
  output logic signed [DW-1:0]   result_o
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned EW = ACCW + 1;

  logic                   v1_q, f1_q, v2_q, f2_q;
  logic signed [PW-1:0]   prod_q, prod_d, bias_q, bias_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [EW-1:0]   ext, rnd, shifted;
  logic signed [SatW-1:0] wide;

  // Stage 1 sees RAM data one cycle after the address; stage 2 one cycle later.
  always_comb begin
    prod_d = v1_q ? PW'(i_rdata_i) * PW'(w_rdata_i) : prod_q;
    bias_d = (v1_q && f1_q) ? b_rdata_i : bias_q;
    acc_d  = acc_q;
    if (v2_q) begin
      acc_d = f2_q ? ACCW'(bias_q) + ACCW'(prod_q) : acc_q + ACCW'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      prod_q <= '0;
      bias_q <= '0;
      acc_q  <= '0;
    end else begin
      v1_q   <= tap_valid_i;
      f1_q   <= tap_first_i;
      v2_q   <= v1_q;
      f2_q   <= f1_q;
      prod_q <= prod_d;
      bias_q <= bias_d;
      acc_q  <= acc_d;
    end
  end

  // One guard bit keeps the rounding add from overflowing.
  always_comb begin
    ext     = EW'(acc_q);
    rnd     = (shift_i == 6'd0) ? '0 : signed'(EW'(1) << (shift_i - 6'd1));
    shifted = (ext + rnd) >>> shift_i;
    if (relu_en_i && shifted[EW-1]) shifted = '0;
    wide     = SatW'(shifted);
    result_o = DW'(saturate(wide, DW));
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution engine: loop counters, RAM addressing and run control.
module conv_stream_engine import conv_pkg::*; #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 32,
  parameter int unsigned N      = 3,
  parameter int unsigned M      = 3,
  parameter int unsigned R      = 28,
  parameter int unsigned C      = 28,
  parameter int unsigned K      = 4,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ACCW   = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            relu_en,
  input  logic [5:0]      shift,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_rdata,
  output logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_rdata,
  output logic [AW-1:0]   b_addr,
  input  logic [2*DW-1:0] b_rdata,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_wdata,
  output logic            o_we
);

  localparam int unsigned RO = ro_of(R, K, STRIDE);
  localparam int unsigned CO = co_of(C, K, STRIDE);
  localparam int unsigned T  = taps_of(N, K);

  if (((R - K) % STRIDE) != 0 || ((C - K) % STRIDE) != 0) begin : g_bad_stride
    $error("conv_stream_engine: (R-K) and (C-K) must be multiples of STRIDE");
  end
  if (ACCW < 2 * DW + clog2(T) + 1) begin : g_bad_accw
    $error("conv_stream_engine: ACCW too narrow for the accumulation depth");
  end

  state_e        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, relu_q, relu_d, flush_q, flush_d;
  logic [5:0]    shift_q, shift_d;
  logic [AW-1:0] m_q, m_d, r_q, r_d, c_q, c_d, n_q, n_d, i_q, i_d, j_q, j_d;
  logic          tap_last, px_last, tap_first;

  assign tap_last = (n_q == AW'(N - 1)) && (i_q == AW'(K - 1)) && (j_q == AW'(K - 1));
  assign px_last  = (m_q == AW'(M - 1)) && (r_q == AW'(RO - 1)) && (c_q == AW'(CO - 1));

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    relu_d  = relu_q;
    shift_d = shift_q;
    flush_d = flush_q;
    {m_d, r_d, c_d, n_d, i_d, j_d} = {m_q, r_q, c_q, n_q, i_q, j_q};
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StIssue;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          relu_d  = relu_en;
          shift_d = shift;
          {m_d, r_d, c_d, n_d, i_d, j_d} = '0;
        end
      end
      StIssue: begin
        j_d = (j_q == AW'(K - 1)) ? '0 : j_q + 1'b1;
        if (j_q == AW'(K - 1)) begin
          i_d = (i_q == AW'(K - 1)) ? '0 : i_q + 1'b1;
          if (i_q == AW'(K - 1)) n_d = (n_q == AW'(N - 1)) ? '0 : n_q + 1'b1;
        end
        if (tap_last) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end
      end
      StFlush: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = StWrite;
      end
      StWrite: begin
        c_d = (c_q == AW'(CO - 1)) ? '0 : c_q + 1'b1;
        if (c_q == AW'(CO - 1)) begin
          r_d = (r_q == AW'(RO - 1)) ? '0 : r_q + 1'b1;
          if (r_q == AW'(RO - 1)) m_d = (m_q == AW'(M - 1)) ? '0 : m_q + 1'b1;
        end
        if (px_last) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      flush_q <= 1'b0;
      {m_q, r_q, c_q, n_q, i_q, j_q} <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      relu_q  <= relu_d;
      shift_q <= shift_d;
      flush_q <= flush_d;
      {m_q, r_q, c_q, n_q, i_q, j_q} <= {m_d, r_d, c_d, n_d, i_d, j_d};
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = (state_q == StIssue);
  assign o_we      = (state_q == StWrite);
  assign tap_first = rd_en && (n_q == '0) && (i_q == '0) && (j_q == '0);

  assign i_addr = n_q * AW'(R * C) + (r_q * AW'(STRIDE) + i_q) * AW'(C)
                + c_q * AW'(STRIDE) + j_q;
  assign w_addr = m_q * AW'(T) + n_q * AW'(K * K) + i_q * AW'(K) + j_q;
  assign b_addr = m_q;
  assign o_addr = m_q * AW'(RO * CO) + r_q * AW'(CO) + c_q;

  conv_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .tap_valid_i (rd_en),
    .tap_first_i (tap_first),
    .i_rdata_i   (i_rdata),
    .w_rdata_i   (w_rdata),
    .b_rdata_i   (b_rdata),
    .shift_i     (shift_q),
    .relu_en_i   (relu_q),
    .result_o    (o_wdata)
  );

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench: two engine configurations, fixed vector table plus random runs.
module tb_conv_stream_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start_v, relu_v;
  logic [5:0] shift_v [2];

  always #5 clk = ~clk;

  logic a_busy, a_done, a_rd_en, a_o_we;
  logic [31:0] a_i_addr, a_w_addr, a_b_addr, a_o_addr;
  logic [7:0] a_i_rdata, a_w_rdata;
  logic [15:0] a_b_rdata;
  logic signed [7:0] a_o_wdata;

  logic b_busy, b_done, b_rd_en, b_o_we;
  logic [31:0] b_i_addr, b_w_addr, b_b_addr, b_o_addr;
  logic [15:0] b_i_rdata, b_w_rdata;
  logic [31:0] b_b_rdata;
  logic signed [15:0] b_o_wdata;

  conv_stream_engine #(.DW(8), .AW(32), .N(1), .M(1), .R(4), .C(4), .K(2), .STRIDE(1),
                       .ACCW(24)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .relu_en(relu_v[0]), .shift(shift_v[0]),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
    .i_addr(a_i_addr), .i_rdata(a_i_rdata), .w_addr(a_w_addr), .w_rdata(a_w_rdata),
    .b_addr(a_b_addr), .b_rdata(a_b_rdata),
    .o_addr(a_o_addr), .o_wdata(a_o_wdata), .o_we(a_o_we)
  );

  conv_stream_engine #(.DW(16), .AW(32), .N(2), .M(2), .R(5), .C(5), .K(3), .STRIDE(2),
                       .ACCW(48)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .relu_en(relu_v[1]), .shift(shift_v[1]),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
    .i_addr(b_i_addr), .i_rdata(b_i_rdata), .w_addr(b_w_addr), .w_rdata(b_w_rdata),
    .b_addr(b_b_addr), .b_rdata(b_b_rdata),
    .o_addr(b_o_addr), .o_wdata(b_o_wdata), .o_we(b_o_we)
  );

  int imem [2][256];
  int wmem [2][256];
  int bmem [2][4];
  int log_addr [2][64];
  int log_data [2][64];
  int wcnt [2];
  int nvec, nerr;

  always_ff @(posedge clk) begin
    if (a_rd_en) begin
      a_i_rdata <= 8'(imem[0][int'(a_i_addr) & 255]);
      a_w_rdata <= 8'(wmem[0][int'(a_w_addr) & 255]);
      a_b_rdata <= 16'(bmem[0][int'(a_b_addr) & 3]);
    end
    if (b_rd_en) begin
      b_i_rdata <= 16'(imem[1][int'(b_i_addr) & 255]);
      b_w_rdata <= 16'(wmem[1][int'(b_w_addr) & 255]);
      b_b_rdata <= 32'(bmem[1][int'(b_b_addr) & 3]);
    end
  end

  always @(negedge clk) begin
    if (a_o_we) begin
      if (wcnt[0] < 64) begin
        log_addr[0][wcnt[0]] = int'(a_o_addr);
        log_data[0][wcnt[0]] = int'(a_o_wdata);
      end
      wcnt[0]++;
    end
    if (b_o_we) begin
      if (wcnt[1] < 64) begin
        log_addr[1][wcnt[1]] = int'(b_o_addr);
        log_data[1][wcnt[1]] = int'(b_o_wdata);
      end
      wcnt[1]++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? a_done : b_done;
  endfunction

  // Reference: direct convolution from the index formulas, then round/ReLU/clamp.
  function automatic int expect_px(input int inst, input int p, input bit relu, input int sh);
    int nn, kk, rr, cc, ss, dw, ro, co, m, r, c;
    longint acc, v, hi;
    if (inst == 0) begin
      nn = 1; kk = 2; rr = 4; cc = 4; ss = 1; dw = 8;
    end else begin
      nn = 2; kk = 3; rr = 5; cc = 5; ss = 2; dw = 16;
    end
    ro = (rr - kk) / ss + 1;
    co = (cc - kk) / ss + 1;
    m = p / (ro * co);
    r = (p / co) % ro;
    c = p % co;
    acc = bmem[inst][m];
    for (int n = 0; n < nn; n++)
      for (int i = 0; i < kk; i++)
        for (int j = 0; j < kk; j++)
          acc += longint'(imem[inst][(n * rr + r * ss + i) * cc + c * ss + j])
               * longint'(wmem[inst][((m * nn + n) * kk + i) * kk + j]);
    v = (sh > 0) ? (acc + (longint'(1) <<< (sh - 1))) >>> sh : acc;
    if (relu && v < 0) v = 0;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    if (v > hi) v = hi;
    else if (v < -hi - 1) v = -hi - 1;
    return int'(v);
  endfunction

  task automatic run(input int inst, input bit relu, input int sh, input int pulse_at,
                     output int cycles, output logic done_next);
    wcnt[inst] = 0;
    @(negedge clk);
    start_v[inst] = 1'b1;
    relu_v[inst]  = relu;
    shift_v[inst] = 6'(sh);
    @(negedge clk);
    start_v[inst] = 1'b0;
    done_next = get_done(inst);
    cycles = 0;
    while (!get_done(inst) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      start_v[inst] = (cycles == pulse_at);
    end
    start_v[inst] = 1'b0;
  endtask

  task automatic check_vs_model(input int inst, input string tag, input bit relu, input int sh);
    int np;
    np = (inst == 0) ? 9 : 8;
    check({tag, "_count"}, wcnt[inst], np);
    for (int k = 0; k < np; k++) begin
      check($sformatf("%s_addr%0d", tag, k), log_addr[inst][k], k);
      check($sformatf("%s_data%0d", tag, k), log_data[inst][k], expect_px(inst, k, relu, sh));
    end
  endtask

  function automatic int rnd_signed(input int amp);
    return int'($urandom_range(0, 2 * amp - 1)) - amp;
  endfunction

  typedef struct {
    int ival;
    int wval;
    int bval;
    bit relu;
    int sh;
    int expv;
  } vec_t;

  vec_t tab [16];
  int cyc, amp, sh, found, saved;
  bit relu;
  logic dn;
  int gold [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{1, 1, 0, 0, 0, 4};
    tab[1]  = '{127, 127, 0, 0, 0, 127};
    tab[2]  = '{127, -128, 0, 0, 0, -128};
    tab[3]  = '{0, 0, -1000, 1, 0, 0};
    tab[4]  = '{0, 0, -1000, 0, 0, -128};
    tab[5]  = '{0, 0, 3, 0, 1, 2};
    tab[6]  = '{0, 0, -3, 0, 1, -1};
    tab[7]  = '{0, 0, 5, 0, 2, 1};
    tab[8]  = '{0, 0, -2, 0, 2, 0};
    tab[9]  = '{1, 1, 0, 1, 0, 4};
    tab[10] = '{1, 1, 0, 0, 2, 1};
    tab[11] = '{-1, 1, -4, 0, 3, -1};
    tab[12] = '{127, 127, 0, 0, 15, 2};
    tab[13] = '{0, 0, 32767, 0, 8, 127};
    tab[14] = '{-5, 3, 0, 1, 0, 0};
    tab[15] = '{-5, 3, 0, 0, 2, -15};

    nvec = 0;
    nerr = 0;
    wcnt[0] = 0;
    wcnt[1] = 0;
    rst_n = 1'b0;
    start_v = '0;
    relu_v = '0;
    shift_v[0] = '0;
    shift_v[1] = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_o_we", a_o_we, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_i_addr", a_i_addr, 0);
    check("rst_w_addr", a_w_addr, 0);
    check("rst_o_addr", a_o_addr, 0);
    check("rst_o_wdata", a_o_wdata, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_b_addr", b_b_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 256; k++) begin
        imem[0][k] = tab[v].ival;
        wmem[0][k] = tab[v].wval;
      end
      bmem[0][0] = tab[v].bval;
      run(0, tab[v].relu, tab[v].sh, -1, cyc, dn);
      check($sformatf("tab%0d_count", v), wcnt[0], 9);
      for (int k = 0; k < 9; k++) begin
        check($sformatf("tab%0d_addr%0d", v, k), log_addr[0][k], k);
        check($sformatf("tab%0d_data%0d", v, k), log_data[0][k], tab[v].expv);
      end
      check($sformatf("tab%0d_cycles", v), cyc, 63);
      if (v == 0) begin
        check("ones_done", a_done, 1);
        check("ones_busy", a_busy, 0);
      end
    end

    // Stride: channel 0 holds its own address, m=0 sums channel 0 only.
    for (int k = 0; k < 256; k++) begin
      imem[1][k] = (k < 25) ? k : rnd_signed(100);
      wmem[1][k] = (k < 9) ? 1 : (k < 18) ? 0 : rnd_signed(50);
    end
    bmem[1][0] = 0;
    bmem[1][1] = rnd_signed(1000);
    run(1, 1'b0, 0, -1, cyc, dn);
    check("stride_px0", log_data[1][0], 54);
    check("stride_px1", log_data[1][1], 72);
    check("stride_px2", log_data[1][2], 144);
    check("stride_px3", log_data[1][3], 162);
    check_vs_model(1, "stride", 1'b0, 0);
    check("stride_cycles", cyc, 168);

    for (int t = 0; t < 6; t++) begin
      amp = 1 << $urandom_range(2, 15);
      for (int k = 0; k < 256; k++) begin
        imem[1][k] = rnd_signed(amp);
        wmem[1][k] = rnd_signed(amp);
      end
      for (int k = 0; k < 4; k++) bmem[1][k] = rnd_signed(amp * amp);
      relu = 1'($urandom_range(0, 1));
      sh = $urandom_range(0, 31);
      run(1, relu, sh, -1, cyc, dn);
      check_vs_model(1, $sformatf("rand%0d", t), relu, sh);
      check($sformatf("rand%0d_cycles", t), cyc, 168);
    end

    // Golden run, then reset during the write of pixel 3, then rerun.
    for (int k = 0; k < 256; k++) begin
      imem[0][k] = rnd_signed(128);
      wmem[0][k] = rnd_signed(128);
    end
    bmem[0][0] = rnd_signed(4000);
    run(0, 1'b0, 3, -1, cyc, dn);
    check_vs_model(0, "gold", 1'b0, 3);
    for (int k = 0; k < 9; k++) gold[k] = log_data[0][k];

    wcnt[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 0;
    for (int t = 0; t < 200 && found == 0; t++) begin
      @(negedge clk);
      if (a_o_we && a_o_addr == 32'd3) found = 1;
    end
    check("rst_mid_found", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_o_we", a_o_we, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_done", a_done, 0);
    check("rst_mid_rd_en", a_rd_en, 0);
    saved = wcnt[0];
    repeat (5) @(negedge clk);
    check("rst_mid_nowrite", wcnt[0], saved);
    rst_n = 1'b1;
    run(0, 1'b0, 3, -1, cyc, dn);
    check("rerun_count", wcnt[0], 9);
    for (int k = 0; k < 9; k++) check($sformatf("rerun_data%0d", k), log_data[0][k], gold[k]);

    // Start pulsed inside a run is ignored; start in DONE launches a fresh run.
    for (int k = 0; k < 256; k++) begin
      imem[0][k] = 1;
      wmem[0][k] = 1;
    end
    bmem[0][0] = 0;
    run(0, 1'b0, 0, 6, cyc, dn);
    check("hs_pulse_count", wcnt[0], 9);
    check("hs_pulse_cycles", cyc, 63);
    check("hs_pulse_done", a_done, 1);
    run(0, 1'b0, 0, -1, cyc, dn);
    check("hs_restart_done_clr", dn, 0);
    check("hs_restart_count", wcnt[0], 9);
    check("hs_restart_cycles", cyc, 63);
    check("hs_restart_data", log_data[0][8], 4);
    check("hs_restart_done", a_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
